tdc_interval_capture: RTL and testbench



---
 rtl/tdc_interval_capture.sv | 100 ++++++++++
 tb/tb_tdc_interval_capture.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tdc_interval_capture.sv
// Start/stop interval capture on a coarse up/down TDC counter. Range is
// extended past COUNT_W by counting wrap-arounds; results leave on valid/ready.
module tdc_interval_capture #(
  parameter int COUNT_W = 4,
  parameter int WRAP_W  = 4
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [COUNT_W-1:0]         count,
  input  logic                       up_dnb,
  input  logic                       start,
  input  logic                       stop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COUNT_W+WRAP_W-1:0]  interval,
  output logic                       overflow,
  output logic                       busy
);
  localparam int RES_W = COUNT_W + WRAP_W;

  typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;

  state_t              state;
  logic [COUNT_W-1:0]  prev_cnt;
  logic [COUNT_W-1:0]  start_cnt;
  logic                dir;
  logic [WRAP_W-1:0]   wraps;
  logic                ovf;

  logic                wrap_hit;
  logic [WRAP_W-1:0]   wraps_nxt;
  logic                ovf_nxt;
  logic [RES_W:0]      base, cnt_x, start_x, raw_res;
  logic                res_ovf;

  assign wrap_hit = ( dir && (prev_cnt == '1) && (count == '0)) ||
                    (!dir && (prev_cnt == '0) && (count == '1));

  // Next wrap/ovf state, also used directly so a wrap on the stop cycle counts.
  always_comb begin
    wraps_nxt = wraps;
    ovf_nxt   = ovf | (up_dnb != dir);
    if (wrap_hit) begin
      if (wraps == '1) ovf_nxt   = 1'b1;
      else             wraps_nxt = wraps + 1'b1;
    end
  end

  // One extra bit so a negative difference shows up as out of range.
  always_comb begin
    base    = {1'b0, wraps_nxt, {COUNT_W{1'b0}}};
    cnt_x   = {{(WRAP_W+1){1'b0}}, count};
    start_x = {{(WRAP_W+1){1'b0}}, start_cnt};
    raw_res = dir ? (base + cnt_x - start_x) : (base + start_x - cnt_x);
    res_ovf = ovf_nxt | raw_res[RES_W];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      prev_cnt  <= '0;
      start_cnt <= '0;
      dir       <= 1'b0;
      wraps     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      interval  <= '0;
    end else begin
      prev_cnt <= count;
      case (state)
        IDLE: if (start) begin
          start_cnt <= count;
          dir       <= up_dnb;
          wraps     <= '0;
          ovf       <= 1'b0;
          busy      <= 1'b1;
          state     <= MEAS;
        end
        MEAS: begin
          wraps <= wraps_nxt;
          ovf   <= ovf_nxt;
          if (stop) begin
            interval  <= res_ovf ? '1 : raw_res[RES_W-1:0];
            overflow  <= res_ovf;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_interval_capture.sv
// Randomized bench for tdc_interval_capture against an unbounded-position
// reference model of the counter and the measurement protocol.
module tb_tdc_interval_capture;
  localparam int COUNT_W = 4;
  localparam int WRAP_W  = 4;
  localparam int RES_W   = COUNT_W + WRAP_W;
  localparam longint RES_MAX = (64'd1 << RES_W) - 1;
  localparam longint WRAP_MAX = (64'd1 << WRAP_W) - 1;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic [COUNT_W-1:0] count = '0;
  logic               up_dnb = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [RES_W-1:0]   interval;
  logic               overflow;
  logic               busy;

  tdc_interval_capture #(.COUNT_W(COUNT_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rstb(rstb), .count(count), .up_dnb(up_dnb),
    .start(start), .stop(stop), .out_valid(out_valid), .out_ready(out_ready),
    .interval(interval), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Counter modelled as an unbounded position; count is its low bits.
  longint pos = 64'd1 << 20;
  bit     ud  = 1'b1;

  // Reference model: 0 idle, 1 measuring, 2 result pending
  int     m_st = 0;
  bit     m_valid = 0, m_busy = 0, m_ovf = 0, m_dchg = 0, m_dir = 0;
  longint m_int = 0, m_sp = 0;

  task automatic model_step();
    longint el, wr;
    if (!rstb) begin
      m_st = 0; m_valid = 0; m_busy = 0; m_ovf = 0; m_int = 0;
      return;
    end
    case (m_st)
      0: if (start) begin
        m_sp = pos; m_dir = up_dnb; m_dchg = 0; m_st = 1; m_busy = 1;
      end
      1: begin
        if (up_dnb != m_dir) m_dchg = 1;
        if (stop) begin
          el = m_dir ? pos - m_sp : m_sp - pos;
          wr = m_dir ? pos / 16 - m_sp / 16 : m_sp / 16 - pos / 16;
          if (m_dchg || wr > WRAP_MAX || el < 0 || el > RES_MAX) begin
            m_int = RES_MAX; m_ovf = 1;
          end else begin
            m_int = el; m_ovf = 0;
          end
          m_st = 2; m_busy = 0; m_valid = 1;
        end
      end
      default: if (out_ready) begin m_valid = 0; m_st = 0; end
    endcase
  endtask

  // One clock: drive inputs, advance model, check at the falling edge.
  task automatic tick(input bit st, input bit sp, input bit rdy, input bit rb, input bit mv);
    if (mv) pos = ud ? pos + 1 : pos - 1;
    count = pos[COUNT_W-1:0];
    up_dnb = ud; start = st; stop = sp; out_ready = rdy; rstb = rb;
    model_step();
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_busy);
    if (m_valid || !rb) begin
      chk("interval", interval, m_int);
      chk("overflow", overflow, m_ovf);
    end
  endtask

  task automatic set_count(input int c);
    pos = ((pos >> 4) << 4) + 64 + c;
  endtask

  // Start at current count, take n moving steps, stop on the last, then accept.
  task automatic meas(input bit d, input int n, input int rdy_dly);
    ud = d;
    tick(1, 0, 0, 1, 0);
    for (int i = 1; i <= n; i++) tick(0, i == n, 0, 1, 1);
    for (int i = 0; i < rdy_dly; i++) tick(0, 0, 0, 1, 0);
    tick(0, 0, 1, 1, 0);
  endtask

  initial begin
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0);                        // stop alone ignored

    set_count(3);  meas(1, 6, 1);              // 3 -> 9: 6
    set_count(14); meas(1, 3, 0);              // 14,15,0,1: 3
    set_count(5);  meas(0, 9, 0);              // 5 down to 12: 9
    set_count(5);  meas(1, 16 * 16 + 2, 0);    // saturation

    // direction toggle mid-measurement
    set_count(7); ud = 1;
    tick(1, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 1); tick(0, 0, 0, 1, 1);
    ud = 0; tick(0, 0, 0, 1, 1);
    ud = 1; tick(0, 1, 0, 1, 1);
    tick(0, 0, 1, 1, 0);

    // backpressure with stray events, then a start right after acceptance
    set_count(2); ud = 1;
    tick(1, 1, 0, 1, 0);                        // start wins over stop
    tick(0, 0, 0, 1, 1); tick(0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) tick(i[0], !i[0], 0, 1, 1);
    tick(0, 0, 1, 1, 0);
    tick(1, 0, 0, 1, 1);
    tick(0, 1, 0, 1, 0);                        // stop right after start, no move
    tick(0, 0, 1, 1, 0);

    // reset mid-measurement, then a lone stop gives nothing
    tick(1, 0, 0, 1, 1); tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 1, 0, 1, 1); tick(0, 0, 1, 1, 0);

    // randomized measurements with stalls, stray events, toggles and resets
    for (int m = 0; m < 40; m++) begin
      int n, dly;
      ud = $urandom_range(0, 1);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 40);
      dly = $urandom_range(0, 4);
      tick(1, $urandom_range(0, 1), 0, 1, $urandom_range(0, 1));
      for (int i = 1; i <= n; i++) begin
        if ($urandom_range(0, 99) == 0) ud = !ud;
        tick($urandom_range(0, 7) == 0, i == n || $urandom_range(0, 49) == 0, 0,
             $urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < dly; i++)
        tick($urandom_range(0, 1), $urandom_range(0, 1), 0, 1, $urandom_range(0, 1));
      tick(0, 0, 1, 1, 0);
      tick($urandom_range(0, 1), 0, 1, 1, 1);
      tick(0, 1, 1, 1, 0);
      tick(0, 0, 1, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
